// File: rtl/sao_offset_calc_if.sv
// Handshake bundle between the CTU statistics accumulator, the SAO offset calculator
// and the downstream offset-decision stage.
interface sao_offset_calc_if #(
   parameter int SUM_W = 14,
   parameter int NUM_W = 10
);
   logic             stat_valid;
   logic             stat_ready;
   logic [SUM_W-1:0] stat_sum;
   logic [NUM_W-1:0] stat_num;
   logic [1:0]       stat_cate;
   logic             stat_last;
   logic             ofs_valid;
   logic             ofs_ready;
   logic [3:0]       ofs_value;
   logic [1:0]       ofs_cate;
   logic             ofs_last;

   modport master (
      output stat_valid, stat_sum, stat_num, stat_cate, stat_last, ofs_ready,
      input  stat_ready, ofs_valid, ofs_value, ofs_cate, ofs_last
   );

   modport slave (
      input  stat_valid, stat_sum, stat_num, stat_cate, stat_last, ofs_ready,
      output stat_ready, ofs_valid, ofs_value, ofs_cate, ofs_last
   );
endinterface

// File: rtl/sao_offset_calc.sv
// SAO offset calculator: rounded |sum|/num via a bit-serial restoring divider,
// then clip and EO sign rule.
//  state  | meaning
//  S_IDLE | ready for a (sum, num) pair
//  S_DIV  | one quotient bit per enabled cycle, MSB first
//  S_OUT  | result presented, waiting for downstream accept
module sao_offset_calc #(
   parameter int diff_clip_bit = 4,
   parameter int num_accu_len  = 9,
   parameter int offset_max    = 7
) (
   input  logic clk,
   input  logic arst_n,
   input  logic en_o,
   sao_offset_calc_if.slave sif
);
   localparam int SUM_W = num_accu_len + diff_clip_bit + 1;
   localparam int NUM_W = num_accu_len + 1;
   localparam int DIV_W = SUM_W + 1;
   localparam int REM_W = NUM_W + 2;
   localparam int CNT_W = $clog2(DIV_W);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] numer_q, numer_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [NUM_W:0]   denom_q, denom_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [3:0]       val_q, val_d;
   logic [1:0]       cate_q, cate_d;
   logic             last_q, last_d;
   logic             live_q;

   logic             accept;
   logic [REM_W-1:0] rem_sh;
   logic             q_bit;
   logic [REM_W-1:0] rem_nx;
   logic [DIV_W-1:0] q_nx;
   logic [SUM_W-1:0] mag;
   logic [3:0]       q_clip;
   logic [3:0]       q_signed;
   logic [3:0]       q_final;

   assign sif.stat_ready = live_q & en_o & (state_q == S_IDLE);
   assign sif.ofs_valid  = (state_q == S_OUT);
   assign sif.ofs_value  = val_q;
   assign sif.ofs_cate   = cate_q;
   assign sif.ofs_last   = last_q;

   assign accept = sif.stat_valid & sif.stat_ready;

   // numer_q shifts the numerator out of its MSB while quotient bits enter at the LSB
   assign rem_sh = {rem_q[REM_W-2:0], numer_q[DIV_W-1]};
   assign q_bit  = (rem_sh >= {1'b0, denom_q});
   assign rem_nx = q_bit ? (rem_sh - {1'b0, denom_q}) : rem_sh;
   assign q_nx   = {numer_q[DIV_W-2:0], q_bit};

   assign mag      = sif.stat_sum[SUM_W-1] ? (~sif.stat_sum + SUM_W'(1)) : sif.stat_sum;
   assign q_clip   = (q_nx > DIV_W'(offset_max)) ? 4'(offset_max) : q_nx[3:0];
   assign q_signed = neg_q ? (4'd0 - q_clip) : q_clip;
   // categories 0,1 keep only positive offsets, 2,3 only negative ones
   assign q_final  = (cate_q[1] ^ neg_q) ? 4'd0 : q_signed;

   always_comb begin
      state_d = state_q;
      numer_d = numer_q;
      rem_d   = rem_q;
      denom_d = denom_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      val_d   = val_q;
      cate_d  = cate_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cate_d = sif.stat_cate;
               last_d = sif.stat_last;
               if (sif.stat_num == '0) begin
                  val_d   = 4'd0;
                  state_d = S_OUT;
               end else begin
                  numer_d = {mag, 1'b0} + DIV_W'(sif.stat_num);
                  denom_d = {sif.stat_num, 1'b0};
                  rem_d   = '0;
                  neg_d   = sif.stat_sum[SUM_W-1];
                  cnt_d   = CNT_W'(DIV_W - 1);
                  state_d = S_DIV;
               end
            end
         end
         S_DIV: begin
            if (en_o) begin
               numer_d = q_nx;
               rem_d   = rem_nx;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  val_d   = q_final;
                  state_d = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (sif.ofs_ready && en_o) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= S_IDLE;
         numer_q <= '0;
         rem_q   <= '0;
         denom_q <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         val_q   <= '0;
         cate_q  <= '0;
         last_q  <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         numer_q <= numer_d;
         rem_q   <= rem_d;
         denom_q <= denom_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         val_q   <= val_d;
         cate_q  <= cate_d;
         last_q  <= last_d;
         live_q  <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sao_offset_calc.sv
// Bench for sao_offset_calc: table vectors and random pairs through a result scoreboard,
// plus hand-written back-pressure, enable-stall and reset-in-flight sequences.
module tb_sao_offset_calc;
   localparam int SUM_W = 14;
   localparam int NUM_W = 10;

   typedef struct {
      int val;
      int cate;
      int last;
   } exp_t;

   typedef struct {
      int s;
      int n;
      int c;
      int l;
      int ev;
   } vec_t;

   logic clk    = 1'b0;
   logic arst_n = 1'b0;
   logic en_o   = 1'b0;

   sao_offset_calc_if #(.SUM_W(SUM_W), .NUM_W(NUM_W)) sif();

   sao_offset_calc dut (
      .clk   (clk),
      .arst_n(arst_n),
      .en_o  (en_o),
      .sif   (sif)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   vec_t tbl[16];

   task automatic check(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model(int s, int n, int c);
      int m, q;
      if (n == 0) return 0;
      m = (s < 0) ? -s : s;
      q = (2 * m + n) / (2 * n);
      if (q > 7) q = 7;
      if (s < 0) q = -q;
      if (c < 2 && q < 0) q = 0;
      if (c >= 2 && q > 0) q = 0;
      return q;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (arst_n && en_o && sif.ofs_valid && sif.ofs_ready) begin
         check("sb_nonempty", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ofs_value", int'($signed(sif.ofs_value)), e.val);
            check("ofs_cate", int'(sif.ofs_cate), e.cate);
            check("ofs_last", int'(sif.ofs_last), e.last);
         end
      end
   end

   // Presents a pair; returns #1 after the accept edge.
   task automatic offer(int s, int n, int c, int l, int ev);
      int   w;
      exp_t e;
      w = 0;
      sif.stat_sum   = SUM_W'(s);
      sif.stat_num   = NUM_W'(n);
      sif.stat_cate  = 2'(c);
      sif.stat_last  = l[0];
      sif.stat_valid = 1'b1;
      @(negedge clk);
      while (!sif.stat_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("accept", int'(sif.stat_ready), 1);
      e.val  = ev;
      e.cate = c;
      e.last = l;
      sb.push_back(e);
      @(posedge clk);
      #1;
      sif.stat_valid = 1'b0;
   endtask

   // Latency counts clock edges with the accept edge as 1.
   task automatic send(int s, int n, int c, int l, int ev, int exp_lat, int stall_at);
      int cyc;
      cyc = 1;
      offer(s, n, c, l, ev);
      while (cyc < 60) begin
         @(negedge clk);
         if (sif.ofs_valid) break;
         if (!en_o) check("stall_ready", int'(sif.stat_ready), 0);
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == stall_at) en_o = 1'b0;
         if (cyc == stall_at + 3) en_o = 1'b1;
      end
      check("latency", cyc, exp_lat);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int s, n, c;
      sif.stat_valid = 1'b0;
      sif.stat_sum   = '0;
      sif.stat_num   = '0;
      sif.stat_cate  = '0;
      sif.stat_last  = 1'b0;
      sif.ofs_ready  = 1'b1;
      en_o           = 1'b1;

      tbl[0]  = '{s:   37, n:   10, c: 0, l: 0, ev:  4};
      tbl[1]  = '{s:  -25, n:   10, c: 3, l: 0, ev: -3};
      tbl[2]  = '{s:  200, n:    5, c: 1, l: 0, ev:  7};
      tbl[3]  = '{s: -8192, n:   1, c: 2, l: 1, ev: -7};
      tbl[4]  = '{s:   20, n:    4, c: 2, l: 0, ev:  0};
      tbl[5]  = '{s:   -6, n:    4, c: 0, l: 0, ev:  0};
      tbl[6]  = '{s:    0, n:    0, c: 1, l: 1, ev:  0};
      tbl[7]  = '{s:   15, n:   10, c: 1, l: 0, ev:  2};
      tbl[8]  = '{s:   14, n:   10, c: 0, l: 1, ev:  1};
      tbl[9]  = '{s:   -7, n:    2, c: 2, l: 0, ev: -4};
      tbl[10] = '{s:   13, n:    2, c: 0, l: 0, ev:  7};
      tbl[11] = '{s:   15, n:    2, c: 1, l: 0, ev:  7};
      tbl[12] = '{s:   -3, n:    1, c: 3, l: 1, ev: -3};
      tbl[13] = '{s: 8191, n: 1023, c: 0, l: 0, ev:  7};
      tbl[14] = '{s:  100, n: 1023, c: 1, l: 0, ev:  0};
      tbl[15] = '{s:   50, n:    0, c: 0, l: 0, ev:  0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stat_ready", int'(sif.stat_ready), 0);
      check("rst_ofs_valid", int'(sif.ofs_valid), 0);
      check("rst_ofs_value", int'(sif.ofs_value), 0);
      check("rst_ofs_cate", int'(sif.ofs_cate), 0);
      check("rst_ofs_last", int'(sif.ofs_last), 0);
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("idle_ready", int'(sif.stat_ready), 1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++)
         send(tbl[i].s, tbl[i].n, tbl[i].c, tbl[i].l, tbl[i].ev, (tbl[i].n == 0) ? 1 : 16, 0);

      for (int i = 0; i < 12; i++) begin
         s = int'($urandom_range(16383)) - 8192;
         n = int'($urandom_range(1023));
         c = int'($urandom_range(3));
         send(s, n, c, i & 1, model(s, n, c), (n == 0) ? 1 : 16, 0);
      end

      // back-pressure: result must hold while downstream is not ready
      sif.ofs_ready = 1'b0;
      send(37, 10, 0, 1, 4, 16, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", int'(sif.ofs_valid), 1);
         check("hold_value", int'($signed(sif.ofs_value)), 4);
         check("hold_last", int'(sif.ofs_last), 1);
         check("hold_ready", int'(sif.stat_ready), 0);
         @(posedge clk);
         #1;
      end
      sif.ofs_ready = 1'b1;
      @(posedge clk);
      #1;

      // enable dropped for three cycles mid-division
      send(-25, 10, 3, 0, -3, 19, 5);

      // reset while dividing discards the pending result
      offer(100, 3, 0, 0, 7);
      repeat (4) @(posedge clk);
      #1;
      arst_n = 1'b0;
      #1;
      check("arst_ofs_valid", int'(sif.ofs_valid), 0);
      check("arst_stat_ready", int'(sif.stat_ready), 0);
      check("arst_ofs_value", int'(sif.ofs_value), 0);
      sb.delete();
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("post_arst_ready", int'(sif.stat_ready), 1);
      check("post_arst_valid", int'(sif.ofs_valid), 0);
      @(posedge clk);
      #1;
      send(-7, 2, 2, 1, -4, 16, 0);

      repeat (3) @(posedge clk);
      check("sb_drained", int'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
